// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, reset fetch address and fetch FSM encoding.
package cpu_pkg;

  localparam int INSTRUCTION_LEN      = 16;
  localparam int INSTRUCTION_MEM_SIZE = 8;
  localparam logic [INSTRUCTION_MEM_SIZE-1:0] RESET_PC = '0;

  typedef logic [INSTRUCTION_LEN-1:0]      instr_t;
  typedef logic [INSTRUCTION_MEM_SIZE-1:0] addr_t;

  typedef enum logic {
    FETCH    = 1'b0,
    REDIRECT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit boundary: instruction memory port, execute redirect/halt and decode handshake.
interface instr_fetch_unit_if
  import cpu_pkg::*;
();

  addr_t  instruction_ptr;
  logic   ipr_write;
  instr_t instruction;
  logic   branch_valid;
  addr_t  branch_target;
  logic   halt;
  logic   ir_valid;
  logic   ir_ready;
  instr_t ir_out;
  addr_t  pc_out;

  modport master (
    output instruction_ptr, ipr_write, ir_valid, ir_out, pc_out,
    input  instruction, branch_valid, branch_target, halt, ir_ready
  );

  modport slave (
    input  instruction_ptr, ipr_write, ir_valid, ir_out, pc_out,
    output instruction, branch_valid, branch_target, halt, ir_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, instr}; flush empties it in one cycle.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full
);

  localparam int DEPTH = 2;

  fetch_entry_t entry_reg [DEPTH];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (push && !flush) begin
      entry_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = entry_reg[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == 2'd2);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, redirect FSM and push/pop control around a 2-entry fetch queue.
module instr_fetch_unit
  import cpu_pkg::*;
(
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master fif
);

  fetch_state_t state_reg, state_next;
  addr_t        pc_reg, pc_next;
  fetch_entry_t hold_reg;
  fetch_entry_t head;
  fetch_entry_t shown;
  logic [1:0]   count;
  logic         full;
  logic         has_entry;
  logic         push;
  logic         pop;

  assign has_entry = (count != 2'd0);
  // A branch kills the head in the same cycle, so decode's ready is ignored then.
  assign pop  = has_entry & fif.ir_ready & ~fif.branch_valid;
  assign push = ~rst & (state_reg == FETCH) & ~fif.halt & ~fif.branch_valid & (~full | pop);

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (fif.branch_valid),
    .din   ('{pc: pc_reg, instr: fif.instruction}),
    .head  (head),
    .count (count),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      hold_reg  <= shown;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (fif.branch_valid) begin
      state_next = REDIRECT;
      pc_next    = fif.branch_target;
    end else begin
      state_next = FETCH;
      if (push) begin
        pc_next = pc_reg + 1'b1;
      end
    end
  end

  // When the queue runs dry the last visible word stays on the outputs.
  assign shown = has_entry ? head : hold_reg;

  assign fif.instruction_ptr = pc_reg;
  assign fif.ipr_write       = push;
  assign fif.ir_valid        = has_entry;
  assign fif.ir_out          = shown.instr;
  assign fif.pc_out          = shown.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with memory model mem[a] = 16'h1000 + a.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .fif (bus)
  );

  always #5 clk = ~clk;

  assign bus.instruction = 16'h1000 + 16'(bus.instruction_ptr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ir_ready = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.halt = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ir_ready = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.halt = 1'b0;
    step();
    step();
    #1;
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid: got %b expected 0", bus.ir_valid); end
    checks++; if (bus.ir_out !== 16'h0000) begin errors++; $display("FAIL rst_ir_out: got %h expected 0000", bus.ir_out); end
    checks++; if (bus.pc_out !== 8'h00) begin errors++; $display("FAIL rst_pc_out: got %h expected 00", bus.pc_out); end
    checks++; if (bus.instruction_ptr !== 8'h00) begin errors++; $display("FAIL rst_iptr: got %h expected 00", bus.instruction_ptr); end
    checks++; if (bus.ipr_write !== 1'b0) begin errors++; $display("FAIL rst_ipr_write: got %b expected 0", bus.ipr_write); end
    rst = 1'b0;
    bus.ir_ready = 1'b1;
    #1;
    checks++; if (bus.ipr_write !== 1'b1) begin errors++; $display("FAIL s1_first_push: got %b expected 1", bus.ipr_write); end
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      $display("s1 xfer pc=%h instr=%h", bus.pc_out, bus.ir_out);
      checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL s1_valid[%0d]: got %b expected 1", k, bus.ir_valid); end
      checks++; if (bus.ir_out !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL s1_ir_out[%0d]: got %h expected %h", k, bus.ir_out, 16'h1000 + 16'(k)); end
      checks++; if (bus.pc_out !== 8'(k)) begin errors++; $display("FAIL s1_pc_out[%0d]: got %h expected %h", k, bus.pc_out, 8'(k)); end
      checks++; if (bus.ipr_write !== 1'b1) begin errors++; $display("FAIL s1_ipr_write[%0d]: got %b expected 1", k, bus.ipr_write); end
    end
  endtask

  task automatic test_backpressure();
    int pushes;
    pushes = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      if (bus.ipr_write === 1'b1) pushes++;
      if (c == 4) begin
        checks++; if (bus.ir_out !== 16'h1000) begin errors++; $display("FAIL s2_hold_ir_out: got %h expected 1000", bus.ir_out); end
        checks++; if (bus.instruction_ptr !== 8'h02) begin errors++; $display("FAIL s2_iptr: got %h expected 02", bus.instruction_ptr); end
        checks++; if (bus.ipr_write !== 1'b0) begin errors++; $display("FAIL s2_ipr_write_full: got %b expected 0", bus.ipr_write); end
        checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL s2_valid_full: got %b expected 1", bus.ir_valid); end
      end
    end
    checks++; if (pushes != 2) begin errors++; $display("FAIL s2_push_count: got %0d expected 2", pushes); end
    step();
    bus.ir_ready = 1'b1;
    #1;
    checks++; if (bus.ipr_write !== 1'b1) begin errors++; $display("FAIL s2_push_on_pop: got %b expected 1", bus.ipr_write); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      $display("s2 xfer pc=%h instr=%h", bus.pc_out, bus.ir_out);
      checks++; if (bus.ir_out !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL s2_ir_out[%0d]: got %h expected %h", k, bus.ir_out, 16'h1000 + 16'(k)); end
      checks++; if (bus.pc_out !== 8'(k)) begin errors++; $display("FAIL s2_pc_out[%0d]: got %h expected %h", k, bus.pc_out, 8'(k)); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    step();
    checks++; if (bus.ir_out !== 16'h1000) begin errors++; $display("FAIL s3_pre_head: got %h expected 1000", bus.ir_out); end
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h40;
    #1;
    checks++; if (bus.ipr_write !== 1'b0) begin errors++; $display("FAIL s3_no_push_branch: got %b expected 0", bus.ipr_write); end
    step();
    bus.branch_valid = 1'b0;
    bus.ir_ready = 1'b1;
    #1;
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL s3_flush_valid: got %b expected 0", bus.ir_valid); end
    checks++; if (bus.instruction_ptr !== 8'h40) begin errors++; $display("FAIL s3_iptr: got %h expected 40", bus.instruction_ptr); end
    checks++; if (bus.ipr_write !== 1'b0) begin errors++; $display("FAIL s3_redirect_push: got %b expected 0", bus.ipr_write); end
    step();
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL s3_bubble_valid: got %b expected 0", bus.ir_valid); end
    checks++; if (bus.ipr_write !== 1'b1) begin errors++; $display("FAIL s3_refetch_push: got %b expected 1", bus.ipr_write); end
    step();
    $display("s3 xfer pc=%h instr=%h", bus.pc_out, bus.ir_out);
    checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL s3_target_valid: got %b expected 1", bus.ir_valid); end
    checks++; if (bus.ir_out !== 16'h1040) begin errors++; $display("FAIL s3_target_ir: got %h expected 1040", bus.ir_out); end
    checks++; if (bus.pc_out !== 8'h40) begin errors++; $display("FAIL s3_target_pc: got %h expected 40", bus.pc_out); end
    step();
    checks++; if (bus.ir_out !== 16'h1041) begin errors++; $display("FAIL s3_next_ir: got %h expected 1041", bus.ir_out); end
  endtask

  task automatic test_wrap();
    logic [7:0]  pc_exp [4];
    logic [15:0] ir_exp [4];
    pc_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    ir_exp = '{16'h10FE, 16'h10FF, 16'h1000, 16'h1001};
    do_reset();
    bus.ir_ready = 1'b1;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'hFE;
    step();
    bus.branch_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      $display("s4 xfer pc=%h instr=%h", bus.pc_out, bus.ir_out);
      checks++; if (bus.pc_out !== pc_exp[k]) begin errors++; $display("FAIL s4_pc_out[%0d]: got %h expected %h", k, bus.pc_out, pc_exp[k]); end
      checks++; if (bus.ir_out !== ir_exp[k]) begin errors++; $display("FAIL s4_ir_out[%0d]: got %h expected %h", k, bus.ir_out, ir_exp[k]); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.ir_ready = 1'b1;
    step();
    step();
    bus.halt = 1'b1;
    #1;
    checks++; if (bus.ipr_write !== 1'b0) begin errors++; $display("FAIL s5_halt_push: got %b expected 0", bus.ipr_write); end
    checks++; if (bus.ir_out !== 16'h1001) begin errors++; $display("FAIL s5_drain_head: got %h expected 1001", bus.ir_out); end
    step();
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL s5_drained_valid: got %b expected 0", bus.ir_valid); end
    checks++; if (bus.instruction_ptr !== 8'h02) begin errors++; $display("FAIL s5_pc_frozen: got %h expected 02", bus.instruction_ptr); end
    checks++; if (bus.ir_out !== 16'h1001) begin errors++; $display("FAIL s5_empty_hold: got %h expected 1001", bus.ir_out); end
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h10;
    step();
    bus.branch_valid = 1'b0;
    #1;
    checks++; if (bus.instruction_ptr !== 8'h10) begin errors++; $display("FAIL s5_branch_in_halt: got %h expected 10", bus.instruction_ptr); end
    checks++; if (bus.ipr_write !== 1'b0) begin errors++; $display("FAIL s5_redirect_push: got %b expected 0", bus.ipr_write); end
    step();
    bus.halt = 1'b0;
    #1;
    checks++; if (bus.ipr_write !== 1'b1) begin errors++; $display("FAIL s5_resume_push: got %b expected 1", bus.ipr_write); end
    step();
    $display("s5 xfer pc=%h instr=%h", bus.pc_out, bus.ir_out);
    checks++; if (bus.ir_out !== 16'h1010) begin errors++; $display("FAIL s5_first_word: got %h expected 1010", bus.ir_out); end
    checks++; if (bus.pc_out !== 8'h10) begin errors++; $display("FAIL s5_first_pc: got %h expected 10", bus.pc_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    step();
    checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL s6_pre_valid: got %b expected 1", bus.ir_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ir_ready = 1'b1;
    #1;
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL s6_valid: got %b expected 0", bus.ir_valid); end
    checks++; if (bus.instruction_ptr !== 8'h00) begin errors++; $display("FAIL s6_iptr: got %h expected 00", bus.instruction_ptr); end
    checks++; if (bus.ir_out !== 16'h0000) begin errors++; $display("FAIL s6_ir_out: got %h expected 0000", bus.ir_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      $display("s6 xfer pc=%h instr=%h", bus.pc_out, bus.ir_out);
      checks++; if (bus.ir_out !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL s6_ir_out[%0d]: got %h expected %h", k, bus.ir_out, 16'h1000 + 16'(k)); end
      checks++; if (bus.pc_out !== 8'(k)) begin errors++; $display("FAIL s6_pc_out[%0d]: got %h expected %h", k, bus.pc_out, 8'(k)); end
    end
  endtask

  initial begin
    bus.ir_ready = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.halt = 1'b0;
    test_reset();
    test_backpressure();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
